// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch PC owner, imem request issue and {pc, instr} queue toward decode
package fetch_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_data;
endpackage

module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        valid_out,
    input  logic        ready_out,
    output fetch_data   data_out
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   r_pc;
    fetch_data     r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic          r_inflight;
    logic [31:0]   r_inflight_pc;

    logic          w_valid;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [AW+1:0] w_occ;
    logic [AW+1:0] w_limit;

    assign w_valid = reset && !redirect_valid && (r_count != '0);
    assign w_pop   = w_valid && ready_out;
    assign w_push  = r_inflight && !redirect_valid;

    // The in-flight request holds a slot; a pop this cycle frees one immediately.
    assign w_occ   = {1'b0, r_count} + {{(AW+1){1'b0}}, r_inflight};
    assign w_limit = (AW+2)'(DEPTH) + {{(AW+1){1'b0}}, w_pop};
    assign w_issue = reset && !redirect_valid && (w_occ < w_limit);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{pc: r_inflight_pc, instr: imem_rdata};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc & ~32'h3;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_issue) begin
                r_pc          <= r_pc + 32'd4;
                r_inflight_pc <= r_pc;
            end
            r_inflight <= w_issue;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign imem_req_valid = w_issue;
    assign imem_addr      = r_pc;
    assign valid_out      = w_valid;
    assign data_out       = r_mem[r_rd_ptr];
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized self-checking bench for fetch_queue against a queue model
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IMEM_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        valid_out;
    logic        ready_out;
    fetch_data   data_out;

    int n_checks = 0;
    int n_fail   = 0;
    int n_req    = 0;

    fetch_data   m_q[$];
    logic [31:0] m_pc;
    logic        m_inflight;
    logic [31:0] m_inflight_pc;
    logic        last_req;
    logic [31:0] last_addr;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .data_out       (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc       = RESET_PC;
        m_inflight = 1'b0;
        last_req   = 1'b0;
        last_addr  = '0;
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic exp_valid;
        logic exp_pop;
        logic exp_req;
        redirect_valid = rv;
        redirect_pc    = rpc;
        ready_out      = rdy;
        imem_rdata     = last_req ? (last_addr ^ IMEM_KEY) : $urandom;
        #1;
        exp_valid = !rv && (m_q.size() != 0);
        exp_pop   = exp_valid && rdy;
        exp_req   = !rv && (m_q.size() + int'(m_inflight) - int'(exp_pop) < int'(DEPTH));
        check("req_valid", 64'(imem_req_valid), 64'(exp_req));
        check("imem_addr", 64'(imem_addr), 64'(m_pc));
        check("valid_out", 64'(valid_out), 64'(exp_valid));
        if (exp_valid) check("data_out", data_out, m_q[0]);
        if (imem_req_valid) n_req++;
        last_req  = imem_req_valid;
        last_addr = imem_addr;
        if (rv) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_pc       = {rpc[31:2], 2'b00};
        end else begin
            if (exp_pop) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back('{pc: m_inflight_pc, instr: imem_rdata});
            m_inflight = exp_req;
            if (exp_req) begin
                m_inflight_pc = m_pc;
                m_pc          = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ready_out      = 1'b0;
        imem_rdata     = '0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_imem_addr", 64'(imem_addr), 64'(RESET_PC));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Streaming from reset with ready held high.
        repeat (12) step(1'b0, '0, 1'b1);

        // Backpressure from an empty queue: exactly DEPTH requests, then resume on first pop.
        step(1'b1, 32'h0, 1'b0);
        n_req = 0;
        repeat (10) step(1'b0, '0, 1'b0);
        check("bp_requests", 64'(n_req), 64'(DEPTH));
        n_req = 0;
        step(1'b0, '0, 1'b1);
        check("bp_resume_req", 64'(n_req), 64'd1);

        // Full occupancy with simultaneous push and pop, pointers wrapping several times.
        repeat (20) step(1'b0, '0, 1'b1);

        // Redirect with three entries queued and one request in flight.
        step(1'b1, 32'h0, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0000_0102, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);

        // Back-to-back redirects: only the last target is fetched.
        step(1'b1, 32'h0000_0200, 1'b1);
        step(1'b1, 32'h0000_0300, 1'b1);
        repeat (8) step(1'b0, '0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), $urandom, ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset while the queue holds entries.
        step(1'b1, 32'h0000_0040, 1'b0);
        repeat (4) step(1'b0, '0, 1'b0);
        ready_out = 1'b1;
        #1;
        check("pre_rst_valid", 64'(valid_out), 64'd1);
        reset = 1'b0;
        #1;
        check("async_rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("async_rst_valid_out", 64'(valid_out), 64'd0);
        check("async_rst_imem_addr", 64'(imem_addr), 64'(RESET_PC));
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        repeat (10) step(1'b0, '0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
